// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: debounced push-buttons and slide switches
// with sticky READY/OVERRUN status, plus writable HEX, LEDR and LEDG
// output registers. The I/O window is the top 16 bytes of the address space.
// ADDR[15:4] is decoded, so DBITS must be at least 16.

// Two-flop synchronizer followed by a counting debouncer for one input group.
module io_debounce #(
    parameter int W        = 4,
    parameter int DEBOUNCE = 500000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] stable_o,
    output logic         event_o
);
    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [W-1:0]  sync1_q, sync2_q;
    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any difference between the synchronized input and the candidate restarts
    // the count; a candidate that has survived the full window is promoted.
    always_comb begin
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        event_o  = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if ((cnt_q == CNT_MAX) && (cand_q != stable_q)) begin
            stable_d = cand_q;
            event_o  = 1'b1;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronizer and debouncer state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
endmodule

module io_ctrl #(
    parameter int DBITS    = 16,
    parameter int DEBOUNCE = 500000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DBITS-1:0] ADDR,
    input  logic             WE,
    input  logic [DBITS-1:0] DIN,
    output logic [DBITS-1:0] DOUT,
    output logic             SEL,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEX,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);
    // Word index within the I/O window (ADDR[3:1]).
    localparam logic [2:0] R_KDATA = 3'd0;
    localparam logic [2:0] R_SDATA = 3'd1;
    localparam logic [2:0] R_KCTRL = 3'd2;
    localparam logic [2:0] R_SCTRL = 3'd3;
    localparam logic [2:0] R_HEX   = 3'd4;
    localparam logic [2:0] R_LEDR  = 3'd5;
    localparam logic [2:0] R_LEDG  = 3'd6;

    logic [3:0]  key_stable;
    logic [9:0]  sw_stable;
    logic        key_ev, sw_ev;
    logic [1:0]  kctrl_q, kctrl_d;   // {OVERRUN, READY}
    logic [1:0]  sctrl_q, sctrl_d;
    logic [15:0] hex_q;
    logic [9:0]  ledr_q;
    logic [7:0]  ledg_q;
    logic        wr_en;
    logic [2:0]  reg_idx;
    logic [15:0] rd16;

    // Keys are active-low on the board; invert so 1 means pressed.
    io_debounce #(.W(4), .DEBOUNCE(DEBOUNCE)) u_key_db (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .raw_i    (~KEY),
        .stable_o (key_stable),
        .event_o  (key_ev)
    );

    io_debounce #(.W(10), .DEBOUNCE(DEBOUNCE)) u_sw_db (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .raw_i    (SW),
        .stable_o (sw_stable),
        .event_o  (sw_ev)
    );

    assign SEL     = (ADDR[15:4] == 12'hFFF);
    assign wr_en   = WE && SEL && !ADDR[0];
    assign reg_idx = ADDR[3:1];

    // Status update: the write clears bits first (write-0-to-clear), then an
    // event sets READY and flags OVERRUN if READY survived the write.
    function automatic logic [1:0] ctrl_next(input logic [1:0] cur, input logic ev,
                                             input logic wr, input logic [1:0] din);
        logic ready_w, ovr_w;
        ready_w = wr ? (cur[0] & din[0]) : cur[0];
        ovr_w   = wr ? (cur[1] & din[1]) : cur[1];
        if (ev) begin
            return {ovr_w | ready_w, 1'b1};
        end
        return {ovr_w, ready_w};
    endfunction

    // Next-state for both status registers.
    always_comb begin
        kctrl_d = ctrl_next(kctrl_q, key_ev, wr_en && (reg_idx == R_KCTRL), DIN[1:0]);
        sctrl_d = ctrl_next(sctrl_q, sw_ev, wr_en && (reg_idx == R_SCTRL), DIN[1:0]);
    end

    // Status and output registers; reset wins over writes and events.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            kctrl_q <= '0;
            sctrl_q <= '0;
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
        end else begin
            kctrl_q <= kctrl_d;
            sctrl_q <= sctrl_d;
            if (wr_en && (reg_idx == R_HEX))  hex_q  <= DIN[15:0];
            if (wr_en && (reg_idx == R_LEDR)) ledr_q <= DIN[9:0];
            if (wr_en && (reg_idx == R_LEDG)) ledg_q <= DIN[7:0];
        end
    end

    // Read mux; anything outside the implemented word map returns DEAD.
    always_comb begin
        rd16 = 16'hDEAD;
        if (SEL && !ADDR[0]) begin
            case (reg_idx)
                R_KDATA: rd16 = {12'b0, key_stable};
                R_SDATA: rd16 = {6'b0, sw_stable};
                R_KCTRL: rd16 = {14'b0, kctrl_q};
                R_SCTRL: rd16 = {14'b0, sctrl_q};
                R_HEX:   rd16 = hex_q;
                R_LEDR:  rd16 = {6'b0, ledr_q};
                R_LEDG:  rd16 = {8'b0, ledg_q};
                default: rd16 = 16'hDEAD;
            endcase
        end
    end

    // Zero-extend the 16-bit read value onto the data bus.
    always_comb begin
        DOUT        = '0;
        DOUT[15:0]  = rd16;
    end

    assign HEX  = hex_q;
    assign LEDR = ledr_q;
    assign LEDG = ledg_q;
endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl with a short debounce window.
module tb_io_ctrl;
    localparam int DB = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] ADDR = 16'h0000;
    logic        WE = 1'b0;
    logic [15:0] DIN = 16'h0000;
    logic [15:0] DOUT;
    logic        SEL;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = 10'h000;
    logic [15:0] HEX;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_sel;
        string       name;
    } vec_t;

    vec_t vecs[14];

    io_ctrl #(.DBITS(16), .DEBOUNCE(DB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ADDR  (ADDR),
        .WE    (WE),
        .DIN   (DIN),
        .DOUT  (DOUT),
        .SEL   (SEL),
        .KEY   (KEY),
        .SW    (SW),
        .HEX   (HEX),
        .LEDR  (LEDR),
        .LEDG  (LEDG)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Combinational read: expected value goes into the queue, compared once DOUT settles.
    task automatic read_reg(input logic [15:0] a, input logic [15:0] exp, input string nm);
        ADDR = a;
        exp_q.push_back(exp);
        #1;
        check(nm, DOUT, exp_q.pop_front());
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DIN  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic w, input logic [15:0] d,
                                input logic [15:0] e, input logic s, input string n);
        vec_t v;
        v.addr = a; v.we = w; v.din = d; v.exp_dout = e; v.exp_sel = s; v.name = n;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(16'hFFF8, 1'b1, 16'h1234, 16'h1234, 1'b1, "wr_hex");
        vecs[1]  = mk(16'hFFFA, 1'b1, 16'hFFFF, 16'h03FF, 1'b1, "wr_ledr");
        vecs[2]  = mk(16'hFFFC, 1'b1, 16'h00A5, 16'h00A5, 1'b1, "wr_ledg");
        vecs[3]  = mk(16'hFFF8, 1'b0, 16'h0000, 16'h1234, 1'b1, "rd_hex");
        vecs[4]  = mk(16'hFFFA, 1'b0, 16'h0000, 16'h03FF, 1'b1, "rd_ledr");
        vecs[5]  = mk(16'hFFFC, 1'b0, 16'h0000, 16'h00A5, 1'b1, "rd_ledg");
        vecs[6]  = mk(16'hFFFE, 1'b0, 16'h0000, 16'hDEAD, 1'b1, "rd_rsvd");
        vecs[7]  = mk(16'hFFF1, 1'b0, 16'h0000, 16'hDEAD, 1'b1, "rd_odd");
        vecs[8]  = mk(16'h0100, 1'b0, 16'h0000, 16'hDEAD, 1'b0, "rd_nosel");
        vecs[9]  = mk(16'hFFF0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "wr_kdata_ro");
        vecs[10] = mk(16'hFFF2, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "wr_sdata_ro");
        vecs[11] = mk(16'hFFF4, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "wr_kctrl_noset");
        vecs[12] = mk(16'hFFFE, 1'b1, 16'h5555, 16'hDEAD, 1'b1, "wr_rsvd");
        vecs[13] = mk(16'hFFF8, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, "sel_dummy");
        vecs[13].exp_sel = 1'b1;

        // Reset
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("rst_hex", HEX, 16'h0000);
        check("rst_ledr", {6'b0, LEDR}, 16'h0000);
        check("rst_ledg", {8'b0, LEDG}, 16'h0000);
        read_reg(16'hFFF4, 16'h0000, "rst_kctrl");
        read_reg(16'hFFF6, 16'h0000, "rst_sctrl");

        // Register map vectors
        for (int i = 0; i < 14; i++) begin
            ADDR = vecs[i].addr;
            DIN  = vecs[i].din;
            WE   = vecs[i].we;
            exp_q.push_back(vecs[i].exp_dout);
            tick();
            WE = 1'b0;
            check(vecs[i].name, DOUT, exp_q.pop_front());
            check({vecs[i].name, "_sel"}, {15'b0, SEL}, {15'b0, vecs[i].exp_sel});
        end
        write_reg(16'hFFF8, 16'h1234);
        check("out_hex", HEX, 16'h1234);
        check("out_ledr", {6'b0, LEDR}, 16'h03FF);
        check("out_ledg", {8'b0, LEDG}, 16'h00A5);

        // Key press latency: stable and READY after the 7th edge, not earlier
        KEY = 4'b1110;
        for (int e = 0; e <= DB + 2; e++) begin
            tick();
            read_reg(16'hFFF0, (e == DB + 2) ? 16'h0001 : 16'h0000, "kdata_lat");
            read_reg(16'hFFF4, (e == DB + 2) ? 16'h0001 : 16'h0000, "kctrl_lat");
        end
        write_reg(16'hFFF4, 16'h0000);
        read_reg(16'hFFF4, 16'h0000, "kctrl_clr");
        read_reg(16'hFFF0, 16'h0001, "kdata_hold");

        // Short glitch on KEY[1]: no event
        KEY = 4'b1100;
        repeat (3) tick();
        KEY = 4'b1110;
        repeat (12) tick();
        read_reg(16'hFFF0, 16'h0001, "glitch_kdata");
        read_reg(16'hFFF4, 16'h0000, "glitch_kctrl");

        // Switch events, overrun, write-0-to-clear
        SW = 10'h001;
        repeat (DB + 3) tick();
        read_reg(16'hFFF2, 16'h0001, "sdata_1");
        read_reg(16'hFFF6, 16'h0001, "sctrl_ready");
        SW = 10'h003;
        repeat (DB + 3) tick();
        read_reg(16'hFFF2, 16'h0003, "sdata_3");
        read_reg(16'hFFF6, 16'h0003, "sctrl_overrun");
        write_reg(16'hFFF6, 16'h0000);
        read_reg(16'hFFF6, 16'h0000, "sctrl_clr_all");
        SW = 10'h007;
        repeat (DB + 3) tick();
        read_reg(16'hFFF6, 16'h0001, "sctrl_ready2");
        SW = 10'h000;
        repeat (DB + 3) tick();
        read_reg(16'hFFF6, 16'h0003, "sctrl_overrun2");
        write_reg(16'hFFF6, 16'h0002);
        read_reg(16'hFFF6, 16'h0002, "sctrl_clr_ready");

        // Event on the same edge as a clearing write with READY=0
        KEY = 4'b1010;
        repeat (DB + 2) tick();
        read_reg(16'hFFF4, 16'h0000, "kctrl_pre_ev");
        write_reg(16'hFFF4, 16'h0000);
        read_reg(16'hFFF4, 16'h0001, "kctrl_ev_wr");
        read_reg(16'hFFF0, 16'h0005, "kdata_5");

        // Reset mid-debounce discards the pending switch change
        SW = 10'h3FF;
        repeat (3) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst2_hex", HEX, 16'h0000);
        check("rst2_ledr", {6'b0, LEDR}, 16'h0000);
        check("rst2_ledg", {8'b0, LEDG}, 16'h0000);
        read_reg(16'hFFF0, 16'h0000, "rst2_kdata");
        read_reg(16'hFFF2, 16'h0000, "rst2_sdata");
        read_reg(16'hFFF4, 16'h0000, "rst2_kctrl");
        read_reg(16'hFFF6, 16'h0000, "rst2_sctrl");
        repeat (DB + 2) tick();
        read_reg(16'hFFF2, 16'h0000, "post_rst_sdata_early");
        read_reg(16'hFFF6, 16'h0000, "post_rst_sctrl_early");
        tick();
        read_reg(16'hFFF2, 16'h03FF, "post_rst_sdata");
        read_reg(16'hFFF6, 16'h0001, "post_rst_sctrl");
        read_reg(16'hFFF0, 16'h0005, "post_rst_kdata");
        read_reg(16'hFFF4, 16'h0001, "post_rst_kctrl");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 16: data/address width.
REQ-002 SHALL have parameter DEBOUNCE, default 500000: consecutive stable cycles required before an input change is accepted; minimum legal value 2.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ADDR, input, DBITS: data-memory address from the processor (registered dmemaddr).
REQ-006 SHALL have port WE, input, 1: processor store strobe.
REQ-007 SHALL have port DIN, input, DBITS: store data.
REQ-008 SHALL have port DOUT, output, DBITS: load data for I/O addresses.
REQ-009 SHALL have port SEL, output, 1: high when ADDR is in the I/O window.
REQ-010 SHALL have port KEY, input, 4: raw push-buttons, active-low, asynchronous.
REQ-011 SHALL have port SW, input, 10: raw slide switches, asynchronous.
REQ-012 SHALL have port HEX, output, 16: value for the four seven-segment decoders.
REQ-013 SHALL have port LEDR, output, 10: red LEDs.
REQ-014 SHALL have port LEDG, output, 8: green LEDs.

Function
REQ-015 SEL SHALL be combinational: ADDR[15:4]==12'hFFF.
REQ-016 Register map (word addresses, ADDR[0]==0): FFF0 KDATA (RO), FFF2 SDATA (RO), FFF4 KCTRL (R/W0C), FFF6 SCTRL (R/W0C), FFF8 HEX (R/W), FFFA LEDR (R/W), FFFC LEDG (R/W), FFFE reserved.
REQ-017 DOUT SHALL be combinational from ADDR and current register state, zero-extended; reserved, odd, or non-SEL addresses return 16'hDEAD.
REQ-018 A write SHALL occur at the rising edge where WE && SEL && ADDR matches; writes to RO or reserved addresses have no effect.
REQ-019 HEX/LEDR/LEDG writes SHALL load DIN[15:0]/DIN[9:0]/DIN[7:0]; new value visible on outputs and DOUT the cycle after the write edge.
REQ-020 KEY SHALL be inverted (1 = pressed) then passed through a 2-flop synchronizer; SW likewise without inversion.
REQ-021 Each group (keys, switches) SHALL have one debouncer: candidate vector, stable vector, saturating counter.
REQ-022 Per edge: if sync != candidate then candidate<=sync, count<=0; else if count==DEBOUNCE-1 and candidate!=stable then stable<=candidate and an event pulses for one cycle; else if count<DEBOUNCE-1 then count<=count+1.
REQ-023 An input held constant SHALL reach stable exactly DEBOUNCE+3 rising edges after the first edge that samples it; any glitch shorter than that SHALL restart the count and produce no event.
REQ-024 KDATA = {12'b0, key stable}; SDATA = {6'b0, switch stable}.
REQ-025 xCTRL bit0 READY SHALL set on group event; bit1 OVERRUN SHALL set on event while READY is already 1; other bits read 0.
REQ-026 Write to xCTRL SHALL clear each of bits 1:0 where DIN bit is 0; writing 1 leaves the bit unchanged; software cannot set bits.
REQ-027 Event and clearing write in the same cycle: READY ends 1; OVERRUN ends 1 only if READY was 1 before the edge and DIN[0]==1.

Reset
REQ-028 RESET SHALL clear synchronizers, candidate, stable, counters, READY, OVERRUN, HEX, LEDR, LEDG to 0 on the next rising edge; it overrides any simultaneous write or event.
REQ-029 Reset mid-debounce SHALL discard the pending change; inputs nonzero after reset SHALL produce a normal event DEBOUNCE+3 edges later.

Verification (DEBOUNCE=4)
REQ-030 Write FFF8=16'h1234, FFFA=16'hFFFF, FFFC=16'h00A5 -> HEX=1234, LEDR=3FF, LEDG=A5; reads return 1234, 03FF, 00A5.
REQ-031 Hold KEY=4'b1110 from edge 0 -> KDATA=0001 and KCTRL=0001 after edge 6, not before.
REQ-032 KEY[1] low 3 cycles then high -> no event; KDATA, KCTRL unchanged.
REQ-033 Two switch events without clear -> SCTRL=0003; write FFF6=0 -> 0000; write 0002 with READY=1 -> READY cleared, OVERRUN kept.
REQ-034 Event coincides with write FFF4=0 while READY=0 -> KCTRL=0001.
REQ-035 Read FFFE, FFF1, 0x0100 -> DOUT=DEAD; SEL=1, 1, 0 respectively; RESET asserted mid-debounce -> all outputs 0, no event.
